// File: rtl/sar_bit_engine.sv
// Successive-approximation bit-trial engine: walks the DAC code from MSB to LSB,
// keeps each bit according to the comparator, and hands back the final code.
module sar_bit_engine #(
    parameter int N_BITS        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_resetb,
    input  logic              adc_convert,
    input  logic              comp_out,
    output logic [N_BITS-1:0] dac_code,
    output logic              adc_done,
    output logic [N_BITS-1:0] data_out,
    output logic              data_valid
);

    localparam int                IDX_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(N_BITS - 1);
    localparam logic [3:0]        CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] MSB_ONLY = {1'b1, {(N_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        TRIAL,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        cnt;
    logic [N_BITS-1:0] trial_code;

    // Code after a decision edge: current bit takes the comparator result,
    // the next lower bit is raised for the following trial.
    always_comb begin
        // NOTE: default assignment first so no path leaves trial_code unassigned (no latch).
        trial_code      = dac_code;
        trial_code[idx] = comp_out;
        if (idx != '0) begin
            trial_code[idx - IDX_W'(1)] = 1'b1;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dac_code   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            adc_done   <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
        end else if (!adc_resetb) begin
            // data_out is intentionally kept so the last result stays readable.
            state      <= IDLE;
            dac_code   <= '0;
            data_valid <= 1'b0;
            adc_done   <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
        end else if (!adc_convert) begin
            // Abort or end of conversion: dac_code holds its value until next start/clear.
            state      <= IDLE;
            adc_done   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    adc_done <= 1'b0;
                    dac_code <= MSB_ONLY;
                    idx      <= IDX_MSB;
                    cnt      <= '0;
                    state    <= TRIAL;
                end
                TRIAL: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        dac_code <= trial_code;
                        if (idx != '0) begin
                            idx <= idx - IDX_W'(1);
                            cnt <= '0;
                        end else begin
                            state      <= DONE;
                            adc_done   <= 1'b1;
                            data_valid <= 1'b1;
                            data_out   <= trial_code;
                        end
                    end
                end
                DONE: begin
                    adc_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_bit_engine.sv
// Directed bench for sar_bit_engine: default instance plus a SETTLE_CYCLES=3 instance,
// each driven by an ideal comparator against a fixed input code.
module tb_sar_bit_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       resetb, convert;
    logic [7:0] vin;
    logic       comp_out;
    logic [7:0] dac_code, data_out;
    logic       done, valid;

    logic       resetb3, convert3;
    logic [7:0] vin3;
    logic       comp_out3;
    logic [7:0] dac_code3, data_out3;
    logic       done3, valid3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign comp_out  = (vin  >= dac_code);
    assign comp_out3 = (vin3 >= dac_code3);

    sar_bit_engine dut (
        .clk(clk), .rst(rst), .adc_resetb(resetb), .adc_convert(convert),
        .comp_out(comp_out), .dac_code(dac_code), .adc_done(done),
        .data_out(data_out), .data_valid(valid)
    );

    sar_bit_engine #(.N_BITS(8), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .adc_resetb(resetb3), .adc_convert(convert3),
        .comp_out(comp_out3), .dac_code(dac_code3), .adc_done(done3),
        .data_out(data_out3), .data_valid(valid3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion and runs until adc_done (bounded), then two more edges
    // with adc_convert still high; counts data_valid pulses along the way.
    task automatic run_conv(input logic [7:0] v, output int edges, output int pulses);
        vin     = v;
        convert = 1'b1;
        edges   = 0;
        pulses  = 0;
        while (edges < 40) begin
            step();
            edges++;
            if (valid) pulses++;
            if (done) break;
        end
        repeat (2) begin
            step();
            if (valid) pulses++;
        end
    endtask

    task automatic finish_conv();
        convert = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; resetb = 1'b1; convert = 1'b0; vin = 8'h00;
        resetb3 = 1'b1; convert3 = 1'b0; vin3 = 8'h00;
        #12;
        n_cmp++;
        if ({dac_code, data_out, done, valid} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got dac=%h data=%h done=%b valid=%b want all 0",
                     dac_code, data_out, done, valid);
        end
        n_cmp++;
        if ({dac_code3, data_out3, done3, valid3} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_outputs3: got dac=%h data=%h done=%b valid=%b want all 0",
                     dac_code3, data_out3, done3, valid3);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_sequence();
        logic [7:0] seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vin    = 8'hA5;
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        convert = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_cmp++;
            if (dac_code !== seq[e-1] || done !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL seq_edge%0d: got dac=%h done=%b valid=%b want dac=%h done=0 valid=0",
                         e, dac_code, done, valid, seq[e-1]);
            end
        end
        step();
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b1 || data_out !== 8'hA5 || dac_code !== 8'hA5) begin
            n_err++;
            $display("FAIL seq_edge9: got done=%b valid=%b data=%h dac=%h want 1 1 a5 a5",
                     done, valid, data_out, dac_code);
        end
        step();
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_hold: got done=%b valid=%b want done=1 valid=0", done, valid);
        end
        convert = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL seq_drop: got done=%b want 0", done);
        end
    endtask

    task automatic test_extremes();
        logic [7:0] codes [2] = '{8'hFF, 8'h00};
        int edges, pulses;
        for (int i = 0; i < 2; i++) begin
            run_conv(codes[i], edges, pulses);
            n_cmp++;
            if (edges !== 9 || pulses !== 1 || data_out !== codes[i]) begin
                n_err++;
                $display("FAIL extreme_%h: got edges=%0d pulses=%0d data=%h want 9 1 %h",
                         codes[i], edges, pulses, data_out, codes[i]);
            end
            finish_conv();
        end
    endtask

    task automatic test_settle3();
        logic [7:0] prev;
        int edges = 0;
        int bad   = 0;
        int early = 0;
        vin3     = 8'h3C;
        convert3 = 1'b1;
        prev     = dac_code3;
        while (edges < 60) begin
            step();
            edges++;
            if (edges > 1 && ((edges - 1) % 3) != 0 && dac_code3 !== prev) bad++;
            if (valid3 && !done3) early++;
            prev = dac_code3;
            if (done3) break;
        end
        n_cmp++;
        if (edges !== 25) begin
            n_err++;
            $display("FAIL settle3_latency: got %0d edges want 25", edges);
        end
        n_cmp++;
        if (bad !== 0 || early !== 0) begin
            n_err++;
            $display("FAIL settle3_cadence: got %0d off-cadence changes, %0d stray valids want 0",
                     bad, early);
        end
        n_cmp++;
        if (data_out3 !== 8'h3C || valid3 !== 1'b1) begin
            n_err++;
            $display("FAIL settle3_result: got data=%h valid=%b want 3c 1", data_out3, valid3);
        end
        convert3 = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int edges, pulses;
        int stray = 0;
        vin     = 8'hA5;
        convert = 1'b1;
        repeat (4) begin
            step();
            if (valid) stray++;
        end
        n_cmp++;
        if (dac_code !== 8'hB0) begin
            n_err++;
            $display("FAIL abort_partial: got dac=%h want b0", dac_code);
        end
        convert = 1'b0;
        step();
        if (valid) stray++;
        n_cmp++;
        if (done !== 1'b0 || stray !== 0 || data_out !== 8'h00 || dac_code !== 8'hB0) begin
            n_err++;
            $display("FAIL abort_idle: got done=%b valids=%0d data=%h dac=%h want 0 0 00 b0",
                     done, stray, data_out, dac_code);
        end
        run_conv(8'hA5, edges, pulses);
        n_cmp++;
        if (edges !== 9 || pulses !== 1 || data_out !== 8'hA5) begin
            n_err++;
            $display("FAIL abort_restart: got edges=%0d pulses=%0d data=%h want 9 1 a5",
                     edges, pulses, data_out);
        end
        finish_conv();
    endtask

    task automatic test_clear();
        int edges, pulses;
        vin     = 8'h3C;
        convert = 1'b1;
        repeat (4) step();
        resetb = 1'b0;
        step();
        n_cmp++;
        if (dac_code !== 8'h00 || done !== 1'b0 || valid !== 1'b0 || data_out !== 8'hA5) begin
            n_err++;
            $display("FAIL clear_mid: got dac=%h done=%b valid=%b data=%h want 00 0 0 a5",
                     dac_code, done, valid, data_out);
        end
        convert = 1'b0;
        resetb  = 1'b1;
        step();
        n_cmp++;
        if (dac_code !== 8'h00 || done !== 1'b0) begin
            n_err++;
            $display("FAIL clear_idle: got dac=%h done=%b want 00 0", dac_code, done);
        end
        run_conv(8'h3C, edges, pulses);
        n_cmp++;
        if (edges !== 9 || data_out !== 8'h3C) begin
            n_err++;
            $display("FAIL clear_restart: got edges=%0d data=%h want 9 3c", edges, data_out);
        end
        finish_conv();
    endtask

    task automatic test_async_reset();
        vin     = 8'hC3;
        convert = 1'b1;
        repeat (9) step();
        n_cmp++;
        if (valid !== 1'b1 || data_out !== 8'hC3) begin
            n_err++;
            $display("FAIL arst_pre: got valid=%b data=%h want 1 c3", valid, data_out);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dac_code, data_out, done, valid, dac_code3, data_out3, done3, valid3} !== 36'h0) begin
            n_err++;
            $display("FAIL arst_async: got dac=%h data=%h done=%b valid=%b data3=%h want all 0",
                     dac_code, data_out, done, valid, data_out3);
        end
        convert = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int edges, pulses;
        run_conv(8'hC3, edges, pulses);
        n_cmp++;
        if (pulses !== 1 || data_out !== 8'hC3 || done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: got pulses=%0d data=%h done=%b want 1 c3 1",
                     pulses, data_out, done);
        end
        convert = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: got done=%b want 0", done);
        end
        run_conv(8'h5A, edges, pulses);
        n_cmp++;
        if (edges !== 9 || pulses !== 1 || data_out !== 8'h5A) begin
            n_err++;
            $display("FAIL b2b_second: got edges=%0d pulses=%0d data=%h want 9 1 5a",
                     edges, pulses, data_out);
        end
        finish_conv();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_extremes();
        test_settle3();
        test_abort();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
